// File: rtl/kw_pkg.sv
// rtl/kw_pkg.sv - shared FSM encodings and field widths for the keyword detection gate
package kw_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LISTEN  = 2'd1;
  localparam logic [1:0] ST_FIRED   = 2'd2;
  localparam logic [1:0] ST_REFRACT = 2'd3;

  // Score width is BIT + SCR_PAD; the DP path length is a fixed 7-bit field.
  localparam int SCR_PAD = 13;
  localparam int LEN_W   = 7;

endpackage

// File: rtl/kw_timeout_cnt.sv
// rtl/kw_timeout_cnt.sv - loadable up-counter with terminal-count flag
module kw_timeout_cnt #(
  parameter int          W    = 8,
  parameter int unsigned TERM = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  // load restarts from zero and takes priority over counting
  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == W'(TERM));

endmodule

// File: rtl/kw_detect_gate.sv
// rtl/kw_detect_gate.sv - confirms keyword hits inside one VAD segment and emits one event per utterance
module kw_detect_gate
  import kw_pkg::*;
#(
  parameter int BIT      = 32,
  parameter int HITS_REQ = 3,
  parameter int GAP_MAX  = 1000000,
  parameter int REFRACT  = 5000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   result_in,
  input  logic                   vad_in,
  input  logic [BIT+SCR_PAD-1:0] scr_in,
  input  logic [LEN_W-1:0]       len_in,
  input  logic                   clear,
  output logic                   det_pulse,
  output logic                   det_flag,
  output logic [BIT+SCR_PAD-1:0] det_scr,
  output logic [LEN_W-1:0]       det_len,
  output logic [7:0]             det_cnt,
  output logic [1:0]             state_o
);

  localparam int         CNT_MAX = (GAP_MAX > REFRACT) ? GAP_MAX : REFRACT;
  localparam int         CW      = $clog2(CNT_MAX + 1);
  localparam logic [3:0] HREQ    = 4'(HITS_REQ);

  logic [1:0]             state;
  logic                   result_d;
  logic [3:0]             hit_cnt;
  logic [3:0]             next_hits;
  logic [BIT+SCR_PAD-1:0] cand_scr;
  logic [LEN_W-1:0]       cand_len;
  logic                   gap_tc;
  logic                   ref_tc;
  logic                   hit;
  logic                   hit_ok;
  logic                   confirm;

  assign hit     = result_in & ~result_d;
  assign hit_ok  = hit && (scr_in != '1) && (len_in != '0);
  assign confirm = (state == ST_LISTEN) && (hit_cnt == HREQ);
  // A hit arriving exactly when the gap expires starts a fresh run of one.
  assign next_hits = gap_tc ? 4'd1 : hit_cnt + 4'd1;
  assign state_o   = state;

  kw_timeout_cnt #(.W(CW), .TERM(GAP_MAX)) u_gap_cnt (
    .clk   (clk),
    .reset (reset),
    .load  ((state != ST_LISTEN) || hit_ok || gap_tc),
    .en    (hit_cnt != 4'd0),
    .tc    (gap_tc)
  );

  kw_timeout_cnt #(.W(CW), .TERM(REFRACT - 1)) u_ref_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (state != ST_REFRACT),
    .en    (1'b1),
    .tc    (ref_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      result_d  <= 1'b0;
      hit_cnt   <= '0;
      cand_scr  <= '0;
      cand_len  <= '0;
      det_pulse <= 1'b0;
      det_flag  <= 1'b0;
      det_scr   <= '0;
      det_len   <= '0;
      det_cnt   <= '0;
    end else begin
      result_d  <= result_in;
      det_pulse <= 1'b0;
      // clear cannot wipe the flag in the cycle the event is being shown
      if (clear && !det_pulse) det_flag <= 1'b0;
      case (state)
        ST_IDLE: begin
          hit_cnt <= '0;
          if (vad_in) state <= ST_LISTEN;
        end
        ST_LISTEN: begin
          if (confirm) begin
            det_pulse <= 1'b1;
            det_flag  <= 1'b1;
            det_scr   <= cand_scr;
            det_len   <= cand_len;
            if (det_cnt != 8'hFF) det_cnt <= det_cnt + 8'd1;
            hit_cnt   <= '0;
            state     <= ST_FIRED;
          end else begin
            if (hit_ok) begin
              hit_cnt  <= next_hits;
              cand_scr <= scr_in;
              cand_len <= len_in;
            end else if (gap_tc) begin
              hit_cnt <= '0;
            end
            // a confirming hit outranks a simultaneous VAD fall
            if (!vad_in && !(hit_ok && next_hits == HREQ)) begin
              state   <= ST_IDLE;
              hit_cnt <= '0;
            end
          end
        end
        ST_FIRED: begin
          if (!vad_in) state <= ST_REFRACT;
        end
        default: begin
          if (ref_tc) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kw_detect_gate.sv
// tb/tb_kw_detect_gate.sv - randomized self-checking bench for kw_detect_gate
module tb_kw_detect_gate;

  localparam int BIT      = 32;
  localparam int HITS_REQ = 3;
  localparam int GAP_MAX  = 50;
  localparam int REFRACT  = 20;
  localparam int SW       = BIT + 13;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          result_in = 1'b0;
  logic          vad_in = 1'b0;
  logic          clear = 1'b0;
  logic [SW-1:0] scr_in = '0;
  logic [6:0]    len_in = 7'd1;
  logic          det_pulse;
  logic          det_flag;
  logic [SW-1:0] det_scr;
  logic [6:0]    det_len;
  logic [7:0]    det_cnt;
  logic [1:0]    state_o;

  kw_detect_gate #(.BIT(BIT), .HITS_REQ(HITS_REQ), .GAP_MAX(GAP_MAX), .REFRACT(REFRACT)) dut (
    .clk(clk), .reset(reset), .result_in(result_in), .vad_in(vad_in), .scr_in(scr_in),
    .len_in(len_in), .clear(clear), .det_pulse(det_pulse), .det_flag(det_flag),
    .det_scr(det_scr), .det_len(det_len), .det_cnt(det_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference: hit timestamps of the current run, phase of the utterance, hold-off countdown.
  int            cyc = 0;
  bit            prev_r = 1'b0;
  int            hits_q[$];
  bit            pending = 1'b0;
  int            m_state = 0;
  int            ref_left = 0;
  bit            m_pulse = 1'b0;
  bit            m_flag = 1'b0;
  int            m_cnt = 0;
  logic [SW-1:0] m_scr = '0;
  logic [SW-1:0] c_scr = '0;
  logic [6:0]    m_len = '0;
  logic [6:0]    c_len = '0;
  int            pulse_err = 0;
  int            state_err = 0;
  int            out_err = 0;
  int            dut_pulses = 0;
  int            model_pulses = 0;
  int            last_pulse_cyc = -1;
  int            last_hit_cyc = -1;

  task automatic model_step();
    bit h;
    bit ok;
    h = result_in && !prev_r;
    prev_r = result_in;
    ok = h && (scr_in != {SW{1'b1}}) && (len_in != 7'd0);
    if (reset) begin
      prev_r = 1'b0; hits_q.delete(); pending = 1'b0; m_state = 0; ref_left = 0;
      m_pulse = 1'b0; m_flag = 1'b0; m_cnt = 0; m_scr = '0; m_len = '0;
    end else begin
      if (clear && !m_pulse) m_flag = 1'b0;
      m_pulse = 1'b0;
      case (m_state)
        0: begin
          hits_q.delete();
          if (vad_in) m_state = 1;
        end
        1: begin
          if (pending) begin
            pending = 1'b0; hits_q.delete(); m_pulse = 1'b1; m_flag = 1'b1;
            m_scr = c_scr; m_len = c_len;
            if (m_cnt < 255) m_cnt++;
            model_pulses++;
            m_state = 2;
          end else begin
            if (ok) begin
              if (hits_q.size() > 0 && (cyc - hits_q[$]) > GAP_MAX) hits_q.delete();
              hits_q.push_back(cyc);
              c_scr = scr_in; c_len = len_in;
              if (hits_q.size() == HITS_REQ) pending = 1'b1;
            end
            if (!vad_in && !pending) begin
              m_state = 0; hits_q.delete();
            end
          end
        end
        2: begin
          if (!vad_in) begin
            m_state = 3; ref_left = REFRACT;
          end
        end
        default: begin
          ref_left--;
          if (ref_left == 0) m_state = 0;
        end
      endcase
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (det_pulse !== m_pulse) pulse_err++;
    if (state_o !== 2'(m_state)) state_err++;
    if (det_flag !== m_flag || det_cnt !== 8'(m_cnt) || det_scr !== m_scr || det_len !== m_len) out_err++;
    if (det_pulse === 1'b1) begin
      dut_pulses++;
      last_pulse_cyc = cyc;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_hit(input logic [SW-1:0] s, input logic [6:0] l);
    scr_in = s; len_in = l; result_in = 1'b1; last_hit_cyc = cyc;
    tick();
    result_in = 1'b0;
    tick();
  endtask

  task automatic end_utt();
    vad_in = 1'b0;
    idle(REFRACT + 4);
  endtask

  function automatic logic [SW-1:0] rnd_scr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[SW-1:0];
  endfunction

  function automatic logic [6:0] rnd_len();
    return 7'($urandom_range(1, 127));
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    compared++; if (det_pulse !== 1'b0 || det_flag !== 1'b0) begin mismatched++; $display("FAIL reset_flags: pulse=%b flag=%b required 0 0", det_pulse, det_flag); end
    compared++; if (det_cnt !== 8'd0 || det_scr !== '0 || det_len !== 7'd0) begin mismatched++; $display("FAIL reset_data: cnt=%0d scr=%0d len=%0d required 0", det_cnt, det_scr, det_len); end
    compared++; if (state_o !== 2'd0) begin mismatched++; $display("FAIL reset_state: got %0d required 0", state_o); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    int p0;
    p0 = dut_pulses;
    vad_in = 1'b1;
    idle(2);
    do_hit(rnd_scr(), rnd_len()); idle($urandom_range(5, 40));
    do_hit(rnd_scr(), rnd_len()); idle($urandom_range(5, 40));
    do_hit(SW'(1000), 7'd10); idle(4);
    compared++; if (dut_pulses - p0 !== 1) begin mismatched++; $display("FAIL basic_count: got %0d pulses required 1", dut_pulses - p0); end
    compared++; if (last_pulse_cyc !== last_hit_cyc + 2) begin mismatched++; $display("FAIL basic_latency: pulse at %0d required %0d", last_pulse_cyc, last_hit_cyc + 2); end
    compared++; if (det_scr !== SW'(1000) || det_len !== 7'd10) begin mismatched++; $display("FAIL basic_latch: scr=%0d len=%0d required 1000 10", det_scr, det_len); end
    compared++; if (det_cnt !== 8'd1 || det_flag !== 1'b1) begin mismatched++; $display("FAIL basic_cnt_flag: cnt=%0d flag=%b required 1 1", det_cnt, det_flag); end
    compared++; if (state_o !== 2'd2) begin mismatched++; $display("FAIL basic_state: got %0d required 2", state_o); end
    end_utt();
    compared++; if (state_o !== 2'd0) begin mismatched++; $display("FAIL basic_idle: got %0d required 0", state_o); end
  endtask

  task automatic test_gap();
    int p0;
    p0 = dut_pulses;
    vad_in = 1'b1;
    idle(2);
    do_hit(rnd_scr(), rnd_len()); idle(10);
    do_hit(rnd_scr(), rnd_len()); idle(58);
    do_hit(rnd_scr(), rnd_len()); idle(18);
    compared++; if (dut_pulses - p0 !== 0) begin mismatched++; $display("FAIL gap_expired: got %0d pulses required 0", dut_pulses - p0); end
    do_hit(rnd_scr(), rnd_len()); idle(28);
    do_hit(rnd_scr(), rnd_len()); idle(3);
    compared++; if (dut_pulses - p0 !== 1 || last_pulse_cyc !== last_hit_cyc + 2) begin mismatched++; $display("FAIL gap_refire: pulses=%0d at %0d required 1 at %0d", dut_pulses - p0, last_pulse_cyc, last_hit_cyc + 2); end
    end_utt();
    p0 = dut_pulses;
    vad_in = 1'b1;
    idle(2);
    do_hit(rnd_scr(), rnd_len()); idle(48);
    do_hit(rnd_scr(), rnd_len()); idle(48);
    do_hit(rnd_scr(), rnd_len()); idle(3);
    compared++; if (dut_pulses - p0 !== 1) begin mismatched++; $display("FAIL gap_exact_max: got %0d pulses required 1", dut_pulses - p0); end
    end_utt();
    p0 = dut_pulses;
    vad_in = 1'b1;
    idle(2);
    do_hit(rnd_scr(), rnd_len()); idle(48);
    do_hit(rnd_scr(), rnd_len()); idle(49);
    do_hit(rnd_scr(), rnd_len()); idle(5);
    compared++; if (dut_pulses - p0 !== 0) begin mismatched++; $display("FAIL gap_max_plus1: got %0d pulses required 0", dut_pulses - p0); end
    end_utt();
  endtask

  task automatic test_vad_drop();
    int p0;
    p0 = dut_pulses;
    vad_in = 1'b1;
    idle(2);
    do_hit(rnd_scr(), rnd_len()); idle(5);
    do_hit(rnd_scr(), rnd_len()); idle(2);
    compared++; if (state_o !== 2'd1) begin mismatched++; $display("FAIL vad_listen: got %0d required 1", state_o); end
    vad_in = 1'b0; tick();
    compared++; if (state_o !== 2'd0) begin mismatched++; $display("FAIL vad_abort: got %0d required 0", state_o); end
    vad_in = 1'b1; tick();
    compared++; if (state_o !== 2'd1) begin mismatched++; $display("FAIL vad_rearm: got %0d required 1", state_o); end
    do_hit(rnd_scr(), rnd_len()); idle(10);
    compared++; if (dut_pulses - p0 !== 0) begin mismatched++; $display("FAIL vad_no_event: got %0d pulses required 0", dut_pulses - p0); end
    end_utt();
  endtask

  task automatic test_refract();
    int p0;
    int n3;
    int first0;
    int first1;
    n3 = 0; first0 = -1; first1 = -1;
    vad_in = 1'b1;
    idle(2);
    for (int k = 0; k < 3; k++) begin
      do_hit(rnd_scr(), rnd_len()); idle(3);
    end
    p0 = dut_pulses;
    for (int i = 0; i < 30; i++) begin
      vad_in = (i >= 5);
      result_in = (i == 6 || i == 8 || i == 10);
      tick();
      if (state_o === 2'd3) n3++;
      if (state_o === 2'd0 && first0 < 0) first0 = i;
      if (state_o === 2'd1 && first1 < 0) first1 = i;
    end
    result_in = 1'b0;
    compared++; if (n3 !== REFRACT) begin mismatched++; $display("FAIL refract_len: got %0d cycles required %0d", n3, REFRACT); end
    compared++; if (first0 !== 20 || first1 !== 21) begin mismatched++; $display("FAIL refract_exit: idle at %0d listen at %0d required 20 21", first0, first1); end
    compared++; if (dut_pulses - p0 !== 0) begin mismatched++; $display("FAIL refract_ignored: got %0d pulses required 0", dut_pulses - p0); end
    idle(1);
    for (int k = 0; k < 3; k++) begin
      do_hit(rnd_scr(), rnd_len()); idle(4);
    end
    compared++; if (dut_pulses - p0 !== 1) begin mismatched++; $display("FAIL refract_refire: got %0d pulses required 1", dut_pulses - p0); end
    end_utt();
  endtask

  task automatic test_invalid();
    int p0;
    logic [SW-1:0] s3;
    p0 = dut_pulses;
    vad_in = 1'b1;
    idle(2);
    do_hit(rnd_scr(), 7'd0); idle(4);
    do_hit({SW{1'b1}}, 7'd5); idle(4);
    do_hit(rnd_scr(), 7'd0); idle(4);
    compared++; if (dut_pulses - p0 !== 0 || state_o !== 2'd1) begin mismatched++; $display("FAIL invalid_skip: pulses=%0d state=%0d required 0 1", dut_pulses - p0, state_o); end
    do_hit(rnd_scr(), 7'd5); idle(4);
    do_hit(rnd_scr(), 7'd5); idle(4);
    s3 = rnd_scr();
    do_hit(s3, 7'd5); idle(3);
    compared++; if (dut_pulses - p0 !== 1) begin mismatched++; $display("FAIL invalid_valid: got %0d pulses required 1", dut_pulses - p0); end
    compared++; if (det_scr !== s3 || det_len !== 7'd5) begin mismatched++; $display("FAIL invalid_latch: scr=%0d len=%0d required %0d 5", det_scr, det_len, s3); end
    end_utt();
  endtask

  task automatic test_random();
    int p0;
    int mp0;
    p0 = dut_pulses; mp0 = model_pulses;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) vad_in = ~vad_in;
      result_in = ($urandom_range(0, 5) == 0);
      scr_in = ($urandom_range(0, 15) == 0) ? {SW{1'b1}} : rnd_scr();
      len_in = ($urandom_range(0, 15) == 0) ? 7'd0 : rnd_len();
      clear = ($urandom_range(0, 30) == 0);
      tick();
    end
    clear = 1'b0; result_in = 1'b0;
    end_utt();
    compared++; if (dut_pulses - p0 !== model_pulses - mp0) begin mismatched++; $display("FAIL random_events: got %0d required %0d", dut_pulses - p0, model_pulses - mp0); end
    compared++; if (pulse_err !== 0) begin mismatched++; $display("FAIL random_pulse_trace: got %0d bad cycles required 0", pulse_err); end
    compared++; if (state_err !== 0) begin mismatched++; $display("FAIL random_state_trace: got %0d bad cycles required 0", state_err); end
    compared++; if (out_err !== 0) begin mismatched++; $display("FAIL random_output_trace: got %0d bad cycles required 0", out_err); end
  endtask

  task automatic test_clear_sat();
    int p0;
    vad_in = 1'b1;
    idle(2);
    do_hit(rnd_scr(), rnd_len()); idle(3);
    do_hit(rnd_scr(), rnd_len()); idle(3);
    do_hit(rnd_scr(), rnd_len());
    compared++; if (det_pulse !== 1'b1) begin mismatched++; $display("FAIL clear_pulse_now: got %b required 1", det_pulse); end
    clear = 1'b1; tick(); clear = 1'b0;
    compared++; if (det_flag !== 1'b1) begin mismatched++; $display("FAIL clear_vs_set: got %b required 1", det_flag); end
    tick();
    clear = 1'b1; tick(); clear = 1'b0;
    compared++; if (det_flag !== 1'b0) begin mismatched++; $display("FAIL clear_plain: got %b required 0", det_flag); end
    end_utt();
    p0 = dut_pulses;
    for (int u = 0; u < 260; u++) begin
      vad_in = 1'b1;
      idle(1);
      for (int k = 0; k < 3; k++) begin
        do_hit(rnd_scr(), rnd_len()); idle($urandom_range(0, 2));
      end
      idle(2);
      end_utt();
    end
    compared++; if (dut_pulses - p0 !== 260) begin mismatched++; $display("FAIL sat_events: got %0d required 260", dut_pulses - p0); end
    compared++; if (det_cnt !== 8'd255) begin mismatched++; $display("FAIL sat_cnt: got %0d required 255", det_cnt); end
  endtask

  task automatic test_reset_mid();
    vad_in = 1'b1;
    idle(2);
    do_hit(rnd_scr(), rnd_len()); idle(2);
    do_hit(rnd_scr(), rnd_len());
    compared++; if (state_o !== 2'd1) begin mismatched++; $display("FAIL midreset_pre: got %0d required 1", state_o); end
    reset = 1'b1; tick();
    compared++; if (state_o !== 2'd0 || det_cnt !== 8'd0 || det_flag !== 1'b0) begin mismatched++; $display("FAIL midreset_ctl: state=%0d cnt=%0d flag=%b required 0 0 0", state_o, det_cnt, det_flag); end
    compared++; if (det_scr !== '0 || det_len !== 7'd0 || det_pulse !== 1'b0) begin mismatched++; $display("FAIL midreset_data: scr=%0d len=%0d pulse=%b required 0", det_scr, det_len, det_pulse); end
    reset = 1'b0; vad_in = 1'b0;
    idle(2);
    compared++; if (pulse_err + state_err + out_err !== 0) begin mismatched++; $display("FAIL whole_run_trace: got %0d bad cycles required 0", pulse_err + state_err + out_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_vad_drop();
    test_refract();
    test_invalid();
    test_random();
    test_clear_sat();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
